fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/fetch_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants for the front end.
// FETCH_MISALIGN_CHK_EN adds the HALT fetch state.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic [1:0] {
    F_REQ, F_WAIT, F_HOLD, F_HALT
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    F_REQ, F_WAIT, F_HOLD
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_buf.sv
// Holding register for the fetched instruction and its PC,
// presented to decode with a valid/ready handshake.
module fetch_buf
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [ILEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      inst_d  = load_inst;
      pc_d    = load_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect handling.
// FETCH_MISALIGN_CHK_EN: misaligned redirect sets misalign and halts.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_e,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            buf_load, buf_flush, buf_valid;
  logic [XLEN-1:0] tgt;

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_br;
  logic misalign_q, misalign_d;
  assign tgt    = br_target;
  assign mis_br = branch_e && (br_target[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;
  assign tgt            = {br_target[XLEN-1:2], 2'b00};
  assign unused_tgt_lsb = ^br_target[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    unique case (state_q)
      F_REQ: begin
        if (branch_e) pc_d = tgt;
        if (imem_req_ready) begin
          state_d = F_WAIT;
          drop_d  = branch_e;
        end
      end
      F_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (branch_e || drop_q) begin
            state_d = F_REQ;
          end else begin
            state_d  = F_HOLD;
            buf_load = 1'b1;
          end
        end else if (branch_e) begin
          drop_d = 1'b1;
        end
        if (branch_e) pc_d = tgt;
      end
      F_HOLD: begin
        if (branch_e) begin
          buf_flush = 1'b1;
          pc_d      = tgt;
          state_d   = F_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = F_REQ;
        end
      end
      default: ;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    // HALT is left only through reset, so a bad redirect overrides all.
    if (mis_br || state_q == F_HALT) begin
      state_d   = F_HALT;
      pc_d      = pc_q;
      drop_d    = 1'b0;
      buf_load  = 1'b0;
      buf_flush = 1'b1;
    end
`endif
  end

  always_comb begin
    imem_req_valid = !rst && (state_q == F_REQ);
    imem_addr      = pc_q;
    inst_valid     = !rst && buf_valid;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_comb misalign_d = misalign_q | mis_br;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_inst (imem_rsp_data),
    .load_pc   (pc_q),
    .flush     (buf_flush),
    .out_ready (inst_ready),
    .out_valid (buf_valid),
    .out_inst  (inst),
    .out_pc    (inst_pc)
  );

endmodule
